// File: rtl/rst_sequencer_pkg.sv
// Shared types and constants for the staged reset sequencer.
package rst_sequencer_pkg;

  typedef enum logic [1:0] {
    RstHold,
    RstPeriph,
    RstRun
  } rst_seq_state_e;

  localparam int unsigned CauseLock = 0;
  localparam int unsigned CauseExt  = 1;
  localparam int unsigned CauseSw   = 2;

  // Wide enough to hold the larger terminal count without wrapping.
  function automatic int unsigned cnt_width(int unsigned a, int unsigned b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/rst_seq_sync.sv
// Multi-flop input synchronizer with a synchronous, active-high clear to ResetValue.
module rst_seq_sync #(
  parameter int unsigned SyncStages = 2,
  parameter logic        ResetValue = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [SyncStages-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {SyncStages{ResetValue}};
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], d_i};
    end
  end

  assign q_o = sync_q[SyncStages-1];

endmodule

// File: rtl/rst_sequencer.sv
// Debounced, ordered release of peripheral then core resets from PLL lock, button and SW request.
// Define RST_SEQUENCER_CAUSE_EN to keep a sticky one-hot record of the last reset cause.
module rst_sequencer
  import rst_sequencer_pkg::*;
#(
  parameter int unsigned SyncStages     = 2,
  parameter int unsigned DebounceCycles = 1024,
  parameter int unsigned CoreDelay      = 64
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       pll_locked_i,
  input  logic       ext_rst_ni,
  input  logic       sw_rst_req_i,
  output logic       rst_periph_no,
  output logic       rst_core_no,
  output logic       rst_done_o,
  output logic [2:0] rst_cause_o
);

  localparam int unsigned CntW = cnt_width(DebounceCycles, CoreDelay);
  localparam logic [CntW-1:0] DbTerm = CntW'(DebounceCycles - 1);
  localparam logic [CntW-1:0] CdTerm = CntW'(CoreDelay - 1);

  logic lock_s, btn_s, clean, fault;
  rst_seq_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic periph_q, periph_d, core_q, core_d, done_q, done_d;

  // Both synchronizers clear to 0: lock lost and button treated as pressed.
  rst_seq_sync #(
    .SyncStages(SyncStages),
    .ResetValue(1'b0)
  ) u_lock_sync (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .d_i  (pll_locked_i),
    .q_o  (lock_s)
  );

  rst_seq_sync #(
    .SyncStages(SyncStages),
    .ResetValue(1'b0)
  ) u_btn_sync (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .d_i  (ext_rst_ni),
    .q_o  (btn_s)
  );

  assign clean = lock_s & btn_s;
  assign fault = ~lock_s | ~btn_s | sw_rst_req_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= RstHold;
      cnt_q    <= '0;
      periph_q <= 1'b0;
      core_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      periph_q <= periph_d;
      core_q   <= core_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RstHold: begin
        if (!clean) begin
          cnt_d = '0;
        end else if (cnt_q == DbTerm) begin
          state_d = RstPeriph;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      RstPeriph: begin
        // A fault on the terminal-count cycle still wins over release.
        if (fault) begin
          state_d = RstHold;
          cnt_d   = '0;
        end else if (cnt_q == CdTerm) begin
          state_d = RstRun;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      RstRun: begin
        if (fault) begin
          state_d = RstHold;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = RstHold;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they flop on the same edge as the state.
  always_comb begin
    periph_d = (state_d != RstHold);
    core_d   = (state_d == RstRun);
    done_d   = (state_d == RstRun);
  end

  assign rst_periph_no = periph_q;
  assign rst_core_no   = core_q;
  assign rst_done_o    = done_q;

`ifdef RST_SEQUENCER_CAUSE_EN
  logic [2:0] cause_q, cause_d;

  always_comb begin
    cause_d = cause_q;
    if ((state_q != RstHold) && (state_d == RstHold)) begin
      cause_d = '0;
      if (!lock_s) begin
        cause_d[CauseLock] = 1'b1;
      end else if (!btn_s) begin
        cause_d[CauseExt] = 1'b1;
      end else begin
        cause_d[CauseSw] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cause_q <= '0;
    end else begin
      cause_q <= cause_d;
    end
  end

  assign rst_cause_o = cause_q;
`else
  assign rst_cause_o = 3'b000;
`endif

endmodule

// File: tb/tb_rst_sequencer.sv
// Self-checking bench for rst_sequencer: directed scenarios, then random inputs vs a timestamp model.
module tb_rst_sequencer;

  localparam int unsigned SS = 2;
  localparam int unsigned DB = 8;
  localparam int unsigned CD = 4;

  logic clk = 1'b0;
  logic rst, lk, btn, sw;
  logic rst_periph_no, rst_core_no, rst_done_o;
  logic [2:0] rst_cause_o;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0=hold 1=periph 2=run, plus edge timestamps.
  int cyc = 0;
  int m_mode = 0;
  int t_enter = 0;
  int t_dirty = 0;
  logic [2:0] m_cause = 3'b000;
  logic lkq[$];
  logic btq[$];

  int edge_no = 0;
  int periph_rise = -1;
  int core_rise = -1;
  int base = 0;

  rst_sequencer #(
    .SyncStages    (SS),
    .DebounceCycles(DB),
    .CoreDelay     (CD)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .pll_locked_i (lk),
    .ext_rst_ni   (btn),
    .sw_rst_req_i (sw),
    .rst_periph_no(rst_periph_no),
    .rst_core_no  (rst_core_no),
    .rst_done_o   (rst_done_o),
    .rst_cause_o  (rst_cause_o)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] exp_cause(input logic [2:0] c);
`ifdef RST_SEQUENCER_CAUSE_EN
    return c;
`else
    return 3'b000;
`endif
  endfunction

  function automatic int maxi(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_pipes();
    lkq.delete();
    btq.delete();
    repeat (SS) begin
      lkq.push_back(1'b0);
      btq.push_back(1'b0);
    end
  endtask

  // Periph releases once DB consecutive clean edges follow the later of HOLD entry and last dirty edge.
  task automatic model_edge(input logic r, input logic l, input logic b, input logic s);
    logic ls, bs, clean, fault;
    cyc++;
    ls = lkq[0];
    bs = btq[0];
    clean = ls & bs;
    fault = !clean || s;
    if (r) begin
      m_mode = 0;
      t_enter = cyc;
      t_dirty = cyc;
      m_cause = 3'b000;
      clear_pipes();
    end else begin
      if (m_mode == 0) begin
        if (!clean) t_dirty = cyc;
        else if (cyc - maxi(t_enter, t_dirty) == int'(DB)) begin
          m_mode = 1;
          t_enter = cyc;
        end
      end else if (fault) begin
        m_mode = 0;
        t_enter = cyc;
        m_cause = !ls ? 3'b001 : (!bs ? 3'b010 : 3'b100);
      end else if (m_mode == 1 && cyc - t_enter == int'(CD)) begin
        m_mode = 2;
        t_enter = cyc;
      end
      void'(lkq.pop_front());
      void'(btq.pop_front());
      lkq.push_back(l);
      btq.push_back(b);
    end
  endtask

  task automatic step(input logic r, input logic l, input logic b, input logic s);
    logic pp, pc;
    rst = r;
    lk = l;
    btn = b;
    sw = s;
    pp = rst_periph_no;
    pc = rst_core_no;
    @(posedge clk);
    model_edge(r, l, b, s);
    if (r) edge_no = 0;
    else edge_no++;
    #1;
    if (!r && pp !== 1'b1 && rst_periph_no === 1'b1) periph_rise = edge_no;
    if (!r && pc !== 1'b1 && rst_core_no === 1'b1) core_rise = edge_no;
    chk("periph", {2'b00, rst_periph_no}, {2'b00, m_mode != 0});
    chk("core", {2'b00, rst_core_no}, {2'b00, m_mode == 2});
    chk("done", {2'b00, rst_done_o}, {2'b00, m_mode == 2});
    chk("cause", rst_cause_o, exp_cause(m_cause));
  endtask

  initial begin
    rst = 1'b1;
    lk = 1'b1;
    btn = 1'b1;
    sw = 1'b0;
    clear_pipes();

    // Power-up: first edge with rst low is edge 1.
    repeat (5) step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("reset_periph", {2'b00, rst_periph_no}, 3'b000);
    chk("reset_cause", rst_cause_o, 3'b000);
    periph_rise = -1;
    core_rise = -1;
    repeat (20) step(1'b0, 1'b1, 1'b1, 1'b0);
    chk_int("pwrup_periph_edge", periph_rise, 10);
    chk_int("pwrup_core_edge", core_rise, 14);

    // Lock loss in RUN: resets drop two edges after the sampling edge.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("lockloss_still_up", {2'b00, rst_periph_no}, 3'b001);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("lockloss_periph", {2'b00, rst_periph_no}, 3'b000);
    chk("lockloss_cause", rst_cause_o, exp_cause(3'b001));
    base = edge_no;
    periph_rise = -1;
    core_rise = -1;
    repeat (20) step(1'b0, 1'b1, 1'b1, 1'b0);
    chk_int("relock_periph_delay", periph_rise - base, 10);
    chk_int("relock_core_delay", core_rise - base, 14);
    chk("relock_cause_sticky", rst_cause_o, exp_cause(3'b001));

    // Software reset in RUN.
    step(1'b0, 1'b1, 1'b1, 1'b1);
    chk("sw_periph", {2'b00, rst_periph_no}, 3'b000);
    chk("sw_cause", rst_cause_o, exp_cause(3'b100));
    base = edge_no;
    periph_rise = -1;
    core_rise = -1;
    repeat (16) step(1'b0, 1'b1, 1'b1, 1'b0);
    chk_int("sw_periph_delay", periph_rise - base, 8);
    chk_int("sw_core_delay", core_rise - base, 12);

    // One-cycle lock glitch while the HOLD counter is at 5.
    repeat (2) step(1'b1, 1'b1, 1'b1, 1'b0);
    periph_rise = -1;
    core_rise = -1;
    repeat (7) step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (16) step(1'b0, 1'b1, 1'b1, 1'b0);
    chk_int("glitch_periph_edge", periph_rise, 18);
    chk_int("glitch_core_edge", core_rise, 22);

    // Lock loss and sw pulse together at the PERIPH terminal count.
    repeat (2) step(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 30 && rst_periph_no !== 1'b1; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("simul_reach_periph", {2'b00, rst_periph_no}, 3'b001);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("simul_pre_periph", {2'b00, rst_periph_no}, 3'b001);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("simul_done", {2'b00, rst_done_o}, 3'b000);
    chk("simul_periph", {2'b00, rst_periph_no}, 3'b000);
    chk("simul_cause", rst_cause_o, exp_cause(3'b001));

    // rst_i while in PERIPH.
    for (int i = 0; i < 30 && rst_periph_no !== 1'b1; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("rstp_reach_periph", {2'b00, rst_periph_no}, 3'b001);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("rstp_periph", {2'b00, rst_periph_no}, 3'b000);
    chk("rstp_core", {2'b00, rst_core_no}, 3'b000);
    chk("rstp_cause", rst_cause_o, 3'b000);

    // Random traffic: mostly clean with occasional glitches, presses, sw pulses and resets.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) < 96),
           ($urandom_range(0, 99) < 97), ($urandom_range(0, 99) < 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
